// File: rtl/apb_pmu_seq_if.sv
// apb_pmu_seq_if: APB bus bundle (psel/penable/pwrite/paddr/pwdata toward the slave, prdata back) with master/slave modports
interface apb_pmu_seq_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic psel, penable, pwrite;
  logic [A_WIDTH-1:0] paddr;
  logic [D_WIDTH-1:0] pwdata, prdata;
  modport master(output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_pmu_seq.sv
// apb_pmu_seq: APB-programmed reset-release sequencer; ports pclk, presetn (async low), apb (slave bus), sys_rst_n (per-domain active-low resets)
module apb_pmu_seq #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int N_DOM = 4,
  parameter int DLY_W = 8,
  parameter int unsigned BOOT_MASK = 1,
  parameter int unsigned DLY_RST = 15
)(
  input  logic             pclk,
  input  logic             presetn,
  apb_pmu_seq_if.slave     apb,
  output logic [N_DOM-1:0] sys_rst_n
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_REL = 2'd2;
  logic [1:0] st, st_nxt;
  logic [N_DOM-1:0] ctrl, pending, rel;
  logic [DLY_W-1:0] dly, cnt, cnt_nxt;
  logic [D_WIDTH-1:0] rdata;
  logic [7:0] addr;
  logic wr, rd, more;
  logic [A_WIDTH+D_WIDTH-1:0] unused_bus;
  assign unused_bus = {apb.paddr, apb.pwdata};
  assign addr = apb.paddr[7:0];
  assign wr = apb.psel & apb.penable & apb.pwrite;
  assign rd = apb.psel & ~apb.penable & ~apb.pwrite;
  assign pending = ctrl & ~sys_rst_n;
  // rel isolates the lowest pending bit; more says another domain still waits after it
  always_comb begin
    rel = st == S_REL ? pending & (~pending + N_DOM'(1)) : '0;
    more = |(pending & ~rel);
    st_nxt = st == S_IDLE ? (|pending ? S_WAIT : S_IDLE)
           : st == S_WAIT ? (cnt == '0 ? S_REL : S_WAIT)
           : more ? S_WAIT : S_IDLE;
    cnt_nxt = (st == S_IDLE && |pending) || (st == S_REL && more) ? dly
            : st == S_WAIT && cnt != '0 ? cnt - DLY_W'(1) : cnt;
    rdata = addr == 8'h00 ? D_WIDTH'(ctrl)
          : addr == 8'h04 ? D_WIDTH'(dly)
          : addr == 8'h08 ? D_WIDTH'({st != S_IDLE, 31'(sys_rst_n)}) : '0;
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      ctrl <= N_DOM'(BOOT_MASK);
      dly <= DLY_W'(DLY_RST);
      st <= S_IDLE;
      cnt <= '0;
      sys_rst_n <= '0;
      apb.prdata <= '0;
    end else begin
      if (wr && addr == 8'h00) ctrl <= apb.pwdata[N_DOM-1:0];
      if (wr && addr == 8'h04) dly <= apb.pwdata[DLY_W-1:0];
      if (rd) apb.prdata <= rdata;
      // clearing wins: release is derived from the current CTRL, so a dropped bit never comes back
      sys_rst_n <= (sys_rst_n & ctrl) | rel;
      st <= st_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: tb/tb_apb_pmu_seq.sv
// tb_apb_pmu_seq: self-checking bench for apb_pmu_seq (register table, release timing, abort, async reset, random sequences)
module tb_apb_pmu_seq;
  logic pclk = 0, presetn = 0;
  logic [3:0] sys;
  logic [31:0] rdv;
  int n_cmp = 0, n_err = 0;
  typedef struct {bit wr; logic [31:0] a, d, exp;} vec_t;
  vec_t tbl[14];
  apb_pmu_seq_if bus();
  apb_pmu_seq dut(.pclk(pclk), .presetn(presetn), .apb(bus.slave), .sys_rst_n(sys));
  always #5 pclk = ~pclk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    bus.psel = 1; bus.pwrite = 1; bus.penable = 0; bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1;
    bus.penable = 1;
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask
  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    bus.psel = 1; bus.pwrite = 0; bus.penable = 0; bus.paddr = a;
    @(posedge pclk); #1;
    bus.penable = 1;
    d = bus.prdata;
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0;
  endtask
  task automatic boot_check(input string name);
    int r;
    r = -1;
    @(negedge pclk);
    presetn = 1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge pclk); #1;
      if (sys[0] && r < 0) r = k;
    end
    check({name, " bit0 rise edge"}, r, 18);
    check({name, " other bits"}, {28'h0, sys[3:1], 1'b0}, 32'h0);
  endtask
  initial begin
    int r[4];
    bit leak;
    tbl = '{
      '{0, 32'h00, 32'h0, 32'h1}, '{0, 32'h04, 32'h0, 32'hF}, '{0, 32'h08, 32'h0, 32'h1},
      '{0, 32'h0C, 32'h0, 32'h0}, '{0, 32'hFC, 32'h0, 32'h0}, '{1, 32'h08, 32'hFFFFFFFF, 32'h0},
      '{0, 32'h08, 32'h0, 32'h1}, '{1, 32'h04, 32'hFFF, 32'h0}, '{0, 32'h04, 32'h0, 32'hFF},
      '{1, 32'h10, 32'hFFFF, 32'h0}, '{0, 32'h00, 32'h0, 32'h1}, '{0, 32'h10, 32'h0, 32'h0},
      '{1, 32'h04, 32'hFFFFFF02, 32'h0}, '{0, 32'h04, 32'h0, 32'h2}};
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset sys_rst_n", sys, 0);
    check("reset prdata", bus.prdata, 0);
    boot_check("boot");
    apb_rd(32'h08, rdv);
    check("boot status", rdv, 32'h1);
    foreach (tbl[i]) begin
      if (tbl[i].wr) apb_wr(tbl[i].a, tbl[i].d);
      else begin
        apb_rd(tbl[i].a, rdv);
        check($sformatf("table read %0d @%h", i, tbl[i].a), rdv, tbl[i].exp);
      end
    end
    apb_wr(32'h00, 32'hF);
    r = '{-1, -1, -1, -1};
    for (int k = 1; k <= 20; k++) begin
      @(posedge pclk); #1;
      for (int i = 1; i < 4; i++) if (sys[i] && r[i] < 0) r[i] = k;
    end
    check("seq bit1 edge", r[1], 5);
    check("seq bit2 edge", r[2], 9);
    check("seq bit3 edge", r[3], 13);
    apb_rd(32'h08, rdv);
    check("seq status done", rdv, 32'hF);
    apb_wr(32'h00, 32'h5);
    @(posedge pclk); #1;
    check("immediate assert", sys, 4'h5);
    apb_rd(32'h08, rdv);
    check("immediate status", rdv, 32'h5);
    apb_wr(32'h00, 32'h1);
    apb_wr(32'h04, 32'h6);
    apb_wr(32'h00, 32'hF);
    r[1] = -1;
    for (int k = 1; k <= 30 && r[1] < 0; k++) begin
      @(posedge pclk); #1;
      if (sys[1]) r[1] = k;
    end
    check("abort bit1 edge", r[1], 9);
    apb_rd(32'h08, rdv);
    check("abort busy status", rdv, 32'h80000003);
    apb_wr(32'h00, 32'h3);
    leak = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge pclk); #1;
      if (sys[3:2] != 0) leak = 1;
    end
    check("abort no release", leak, 0);
    apb_rd(32'h08, rdv);
    check("abort status", rdv, 32'h3);
    apb_wr(32'h00, 32'hF);
    repeat (4) @(posedge pclk);
    #3;
    presetn = 0;
    #1;
    check("async sys_rst_n", sys, 0);
    check("async prdata", bus.prdata, 0);
    repeat (2) @(posedge pclk);
    boot_check("reboot");
    apb_rd(32'h04, rdv);
    check("reboot delay", rdv, 32'hF);
    apb_rd(32'h00, rdv);
    check("reboot ctrl", rdv, 32'h1);
    begin
      logic [3:0] prev, c, nb, e;
      int d, idx, hz;
      prev = 4'h1;
      for (int it = 0; it < 16; it++) begin
        d = $urandom_range(0, 5);
        c = 4'($urandom_range(0, 15));
        apb_wr(32'h04, d);
        apb_wr(32'h00, {28'h0, c});
        nb = c & ~prev;
        hz = d + 3 + 3 * (d + 2) + 1;
        for (int k = 1; k <= hz; k++) begin
          @(posedge pclk); #1;
          e = prev & c;
          idx = 0;
          for (int i = 0; i < 4; i++)
            if (nb[i]) begin
              if (k >= d + 3 + idx * (d + 2)) e[i] = 1'b1;
              idx++;
            end
          check($sformatf("rand %0d edge %0d sys", it, k), sys, e);
        end
        apb_rd(32'h08, rdv);
        check($sformatf("rand %0d status", it), rdv, {28'h0, c});
        prev = c;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_pmu_seq.md
APB_PMU_SEQ -- requirements
Module: apb_pmu_seq

Interface
- REQ-001 SHALL have parameter A_WIDTH, default 32, APB address width.
- REQ-002 SHALL have parameter D_WIDTH, default 32, APB data width; only 32 is supported.
- REQ-003 SHALL have parameter N_DOM, default 4, number of reset domains; legal range 1..16.
- REQ-004 SHALL have parameter DLY_W, default 8, inter-domain delay counter width; legal range 1..16.
- REQ-005 SHALL have parameter BOOT_MASK, default 1, CTRL value loaded at reset.
- REQ-006 SHALL have parameter DLY_RST, default 15, DELAY value loaded at reset.
- REQ-007 SHALL have port pclk, input, 1 bit, sole clock, all logic on its rising edge.
- REQ-008 SHALL have port presetn, input, 1 bit, asynchronous active-low reset.
- REQ-009 SHALL have ports psel, penable, pwrite, each input, 1 bit, APB select, enable and direction.
- REQ-010 SHALL have ports paddr (input, A_WIDTH) and pwdata (input, D_WIDTH), APB address and write data.
- REQ-011 SHALL have port prdata, output, D_WIDTH, registered read data.
- REQ-012 SHALL have port sys_rst_n, output, N_DOM bits, per-domain active-low reset, registered.

Function
- REQ-013 SHALL perform a write when psel & penable & pwrite, at that edge.
- REQ-014 SHALL capture read data into prdata when psel & !penable & !pwrite (setup phase); prdata SHALL otherwise hold its value.
- REQ-015 SHALL decode paddr[7:0] as follows:
  - 0x00 CTRL, RW, bits [N_DOM-1:0] = release request mask.
  - 0x04 DELAY, RW, bits [DLY_W-1:0].
  - 0x08 STATUS, RO: [N_DOM-1:0] = sys_rst_n, [31] = busy (FSM not IDLE).
- REQ-016 SHALL read unimplemented bits and unmapped addresses as 0, and SHALL ignore writes to them and to STATUS.
- REQ-017 SHALL have sequencer FSM states IDLE, WAIT, RELEASE, plus a DLY_W-bit down-counter cnt.
- REQ-018 SHALL transition IDLE->WAIT when pending = CTRL & ~sys_rst_n is nonzero, loading cnt = DELAY; otherwise it SHALL stay in IDLE.
- REQ-019 SHALL, in WAIT, go to RELEASE when cnt==0, else decrement cnt; WAIT therefore lasts DELAY+1 cycles.
- REQ-020 SHALL, in RELEASE, set the lowest-index pending bit of sys_rst_n, then go to WAIT with cnt reloaded if other pending bits remain, else to IDLE.
- REQ-021 SHALL, in RELEASE with pending==0 (requests withdrawn), set no bit and go to IDLE.
- REQ-022 SHALL raise the released sys_rst_n bit DELAY+3 edges after the CTRL write edge for a single request from IDLE.
- REQ-023 SHALL release successive domains DELAY+2 edges apart, in ascending index order.
- REQ-024 SHALL assert reset immediately: any bit with CTRL=0 SHALL drive sys_rst_n low at the next edge, in any state, without sequencing.
- REQ-025 SHALL compute the next sys_rst_n as (sys_rst_n & CTRL) | release_onehot, so clear wins because release is derived from current CTRL.
- REQ-026 SHALL apply a DELAY write only at the next cnt reload; an in-progress count SHALL be unaffected.
- REQ-027 SHALL treat a CTRL write during WAIT/RELEASE as updating pending on the following edge; the FSM SHALL NOT restart cnt.
- REQ-028 SHALL treat DELAY=0 as legal: WAIT lasts one cycle.

Reset
- REQ-029 SHALL, while presetn is low, hold sys_rst_n = 0, prdata = 0, CTRL = BOOT_MASK, DELAY = DLY_RST, FSM = IDLE, cnt = 0.
- REQ-030 SHALL restart sequencing of BOOT_MASK domains after presetn deasserts, per REQ-018..REQ-023.
- REQ-031 SHALL, when presetn is asserted mid-sequence, drive all sys_rst_n low asynchronously and discard the sequence.

Verification
- REQ-032 Boot: defaults, release presetn -> sys_rst_n[0] rises at edge 18 (15+3); other bits stay 0; STATUS reads 0x1.
- REQ-033 Sequence: DELAY=2, then CTRL=0xF -> bits 1,2,3 rise 5, 9, 13 edges after the write edge; busy=1 throughout, 0 after.
- REQ-034 Abort: during WAIT for bit 2, write CTRL=0x3 -> bit 2 never rises, FSM returns IDLE, STATUS=0x3.
- REQ-035 Immediate assert: with all released, write CTRL=0x5 -> bits 1 and 3 low at the next edge, no delay.
- REQ-036 Bus: read 0x0C -> prdata=0; write 0x08=0xFFFFFFFF -> STATUS unchanged; reading DELAY after writing 0xFFF with DLY_W=8 -> 0xFF.
- REQ-037 Async reset: assert presetn mid-WAIT -> all outputs 0 without a clock edge; on release -> BOOT_MASK sequence restarts.
